// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the M-extension unit: op encodings, FSM states and a
// conditional two's-complement negate used for operand magnitudes and sign fix-up.
package muldiv_unit_pkg;

  localparam int MAX_XLEN = 64;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_e;

  // Callers zero-extend into MAX_XLEN and truncate back; the low bits of a
  // two's-complement negate do not depend on the upper bits.
  function automatic logic [MAX_XLEN-1:0] cond_neg(input logic [MAX_XLEN-1:0] v,
                                                   input logic neg);
    return neg ? (~v + MAX_XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct3;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out;
  logic            busy;

  modport master (
    output flush, in_valid, funct3, in1, in2, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  flush, in_valid, funct3, in1, in2, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/muldiv_unit_div_step.sv
// Combinational restoring-division step: retires DIV_BITS quotient bits, MSB first.
// quo_in carries the not-yet-consumed dividend bits; quotient bits shift in at the LSB.
module muldiv_div_step #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);
  logic [XLEN-1:0] rem_s [DIV_BITS+1];
  logic [XLEN-1:0] quo_s [DIV_BITS+1];

  assign rem_s[0] = rem_in;
  assign quo_s[0] = quo_in;

  for (genvar gi = 0; gi < DIV_BITS; gi++) begin : g_bit
    logic [XLEN:0] partial;
    logic [XLEN:0] diff;

    assign partial = {rem_s[gi], quo_s[gi][XLEN-1]};
    // Bit XLEN of diff is the borrow: set means the divisor did not fit.
    assign diff         = partial - {1'b0, divisor};
    assign rem_s[gi+1]  = diff[XLEN] ? partial[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_s[gi+1]  = {quo_s[gi][XLEN-2:0], ~diff[XLEN]};
  end

  assign rem_out = rem_s[DIV_BITS];
  assign quo_out = quo_s[DIV_BITS];
endmodule

// File: rtl/muldiv_unit.sv
// Handshaked RV M-extension unit: fixed-latency multiply, iterative radix-2^DIV_BITS divide.
// One operation outstanding; flush or reset returns it to IDLE.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1,
  parameter int MUL_LAT  = 2
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);
  localparam int N_ITER = XLEN / DIV_BITS;
  localparam int CNT_W  = $clog2(N_ITER + MUL_LAT + 1);
  localparam int PIPE_D = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [XLEN-1:0] out_reg, out_next;
  logic [XLEN-1:0] rem_reg, quo_reg, dvs_reg;
  logic            neg_q_reg, neg_r_reg, is_rem_reg;
  logic [XLEN-1:0] mul_pipe_reg [PIPE_D];

  muldiv_op_e      op;
  logic            accept;
  logic            sgn_a, sgn_b;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0] mul_now, mul_tail;
  logic            sgn_div, is_rem, div_zero, div_ovf, div_special;
  logic [XLEN-1:0] special_res, a_abs, b_abs;
  logic [XLEN-1:0] step_rem, step_quo, q_fix, r_fix;

  assign op     = muldiv_op_e'(bus.funct3);
  assign accept = (state_reg == ST_IDLE) && bus.in_valid && !bus.flush;

  // Multiply on XLEN+1-bit sign-extended operands, evaluated modulo 2^(2*XLEN).
  assign sgn_a   = ((op == OP_MULH) || (op == OP_MULHSU)) && bus.in1[XLEN-1];
  assign sgn_b   = (op == OP_MULH) && bus.in2[XLEN-1];
  assign mul_a   = {{XLEN{sgn_a}}, bus.in1};
  assign mul_b   = {{XLEN{sgn_b}}, bus.in2};
  assign prod    = mul_a * mul_b;
  assign mul_now = (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign mul_tail = mul_pipe_reg[PIPE_D-1];

  assign sgn_div     = (op == OP_DIV) || (op == OP_REM);
  assign is_rem      = (op == OP_REM) || (op == OP_REMU);
  assign div_zero    = (bus.in2 == '0);
  assign div_ovf     = sgn_div && (bus.in1 == MOST_NEG) && (bus.in2 == '1);
  assign div_special = div_zero || div_ovf;
  assign special_res = is_rem ? (div_zero ? bus.in1 : '0) : (div_zero ? '1 : bus.in1);

  assign a_abs = XLEN'(cond_neg(MAX_XLEN'(bus.in1), sgn_div && bus.in1[XLEN-1]));
  assign b_abs = XLEN'(cond_neg(MAX_XLEN'(bus.in2), sgn_div && bus.in2[XLEN-1]));

  muldiv_div_step #(
    .XLEN     (XLEN),
    .DIV_BITS (DIV_BITS)
  ) u_div_step (
    .rem_in  (rem_reg),
    .quo_in  (quo_reg),
    .divisor (dvs_reg),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // Sign fix-up applied to the last step's output, folded into the DONE transition.
  assign q_fix = XLEN'(cond_neg(MAX_XLEN'(step_quo), neg_q_reg));
  assign r_fix = XLEN'(cond_neg(MAX_XLEN'(step_rem), neg_r_reg));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    out_next   = out_reg;
    if (bus.flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.in_valid) begin
            if (!bus.funct3[2]) begin
              if (MUL_LAT == 1) begin
                state_next = ST_DONE;
                out_next   = mul_now;
              end else begin
                state_next = ST_MUL;
                cnt_next   = CNT_W'(MUL_LAT - 2);
              end
            end else if (div_special) begin
              state_next = ST_DONE;
              out_next   = special_res;
            end else begin
              state_next = ST_DIV;
              cnt_next   = CNT_W'(N_ITER - 1);
            end
          end
        end
        ST_MUL: begin
          if (cnt_reg == '0) begin
            state_next = ST_DONE;
            out_next   = mul_tail;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        ST_DIV: begin
          if (cnt_reg == '0) begin
            state_next = ST_DONE;
            out_next   = is_rem_reg ? r_fix : q_fix;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg    <= '0;
      quo_reg    <= '0;
      dvs_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      is_rem_reg <= 1'b0;
      for (int i = 0; i < PIPE_D; i++) mul_pipe_reg[i] <= '0;
    end else begin
      if (accept) begin
        rem_reg    <= '0;
        quo_reg    <= a_abs;
        dvs_reg    <= b_abs;
        neg_q_reg  <= sgn_div && (bus.in1[XLEN-1] ^ bus.in2[XLEN-1]);
        neg_r_reg  <= sgn_div && bus.in1[XLEN-1];
        is_rem_reg <= is_rem;
        mul_pipe_reg[0] <= mul_now;
      end else if (state_reg == ST_DIV) begin
        rem_reg <= step_rem;
        quo_reg <= step_quo;
      end
      for (int i = PIPE_D - 1; i > 0; i--) mul_pipe_reg[i] <= mul_pipe_reg[i-1];
    end
  end

  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.out       = out_reg;
endmodule
